nx1_zbus_master: RTL and testbench
==================================

Name: nx1_zbus_master

Overview:
Z80-style bus cycle initiator for the X1 system bus. Converts single-beat host transactions (memory or I/O, read or write) into MREQ_n/IORQ_n/RD_n/WR_n cycles with T1/T2/TW/T3 timing. Output drives the system address decoder and peripherals. Used by loader/debug/DMA-style agents that must access X1 memory and I/O space as the CPU would.

Parameters:
TSTATE_CLKS, 1, I_CLK cycles per T-state (1..15); internal 4-bit divider counter.
IO_AUTO_WAIT, 1, number of automatic TW states inserted after T2 on I/O cycles (0..3).
WAIT_MAX, 255, TW-state limit before forced completion (used only with the optional feature).

Ports:
I_CLK  in  1  system clock
I_RESET_n  in  1  asynchronous active-low reset
I_REQ  in  1  host request, level; sampled only in IDLE
I_IO  in  1  1=I/O cycle (IORQ_n), 0=memory cycle (MREQ_n)
I_WE  in  1  1=write, 0=read
I_ADDR  in  16  cycle address
I_WDATA  in  8  write data
O_ACK  out  1  one-clock completion pulse
O_RDATA  out  8  read data, valid from the O_ACK cycle until the next read completes
O_BUSY  out  1  high in any state other than IDLE
O_TIMEOUT  out  1  sticky wait-timeout flag (optional feature)
O_A  out  16  bus address
O_D  out  8  bus write data
O_D_OE  out  1  bus data drive enable
I_D  in  8  bus read data
O_MREQ_n, O_IORQ_n, O_RD_n, O_WR_n  out  1 each  bus strobes, active low
I_WAIT_n  in  1  bus wait, active low

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE. All strobes=1, O_D_OE=0, O_ACK=0, O_BUSY=0, O_A=0, O_D=0, O_RDATA=0, O_TIMEOUT=0.
- States: IDLE, T1, T2, TWA, TW, T3, DONE. Each of T1/T2/TWA/TW/T3 lasts TSTATE_CLKS clocks. IDLE and DONE last 1 clock.
- IDLE: if I_REQ=1, latch I_ADDR/I_WDATA/I_IO/I_WE and go to T1.
- T1: O_A=latched address. For writes, O_D=data and O_D_OE=1. Strobes remain inactive.
- T2: assert MREQ_n or IORQ_n per I_IO. Assert RD_n or WR_n per I_WE. Strobes and O_D_OE stay asserted until T3 ends.
  - Memory cycle: on the last clock of T2, go to TW if I_WAIT_n=0, else T3.
  - I/O cycle: go to TWA. Stay there IO_AUTO_WAIT T-states, then sample I_WAIT_n on the last clock of the final TWA. If IO_AUTO_WAIT=0, sample at the end of T2.
- TW: on the last clock of each TW, stay in TW if I_WAIT_n=0, else go to T3.
- T3: reads capture I_D into O_RDATA on the last clock of T3. Then go to DONE.
- DONE: all strobes=1, O_D_OE=0, O_ACK=1 for exactly one clock, then IDLE. I_REQ is ignored in DONE; the host drops I_REQ in the ACK clock or a new cycle starts from IDLE on the next clock.
- O_A holds its last value in IDLE/DONE. Strobe and address outputs are registered and glitch-free.
- Latency, TSTATE_CLKS=1, no waits: memory cycle O_ACK 4 clocks after the accepting edge; I/O cycle 5 clocks with IO_AUTO_WAIT=1. Each wait T-state adds TSTATE_CLKS clocks.
- Only one strobe pair is ever active. RD_n and WR_n are never both low.
- Address/data inputs that change after acceptance have no effect on the current cycle.

Optional Feature:
ZBUS_WAIT_TIMEOUT_EN: an 8-bit TW counter runs.
- When the count reaches WAIT_MAX with I_WAIT_n still 0, force T3 and set O_TIMEOUT=1.
- O_TIMEOUT clears only at the next accepted request or on reset.
- A read data value is still captured in that case.
Without the macro: TW repeats indefinitely while I_WAIT_n=0, and O_TIMEOUT is tied to 0.

Test Plan:
- Memory read A=0x8000, I_D=0x5A, I_WAIT_n=1, TSTATE_CLKS=1 -> MREQ_n/RD_n low for 2 clocks (T2,T3), O_ACK 4 clocks after accept, O_RDATA=0x5A.
- I/O write A=0x1A02, WDATA=0xC3, IO_AUTO_WAIT=1 -> IORQ_n/WR_n low 3 clocks, O_D=0xC3 with O_D_OE=1 from T1 through T3, O_ACK at clock 5, MREQ_n stays 1.
- Memory write with I_WAIT_n=0 for 3 T-states from T2 -> exactly 3 TW states, strobes held low throughout, O_ACK at clock 7.
- TSTATE_CLKS=4, memory read -> T1/T2/T3 each 4 clocks, O_ACK at clock 13, I_D sampled at clock 12.
- Assert I_RESET_n=0 during TW of an I/O read -> strobes=1 and O_D_OE=0 immediately, no O_ACK. The next request after release completes normally.
- With ZBUS_WAIT_TIMEOUT_EN, WAIT_MAX=4, I_WAIT_n held 0 -> 4 TW states, then T3, O_ACK, O_TIMEOUT=1. Flag clears on the next accepted request.

Source files
------------

// File: rtl/nx1_zbus_master_if.sv
// Host-side request/ack and X1 system-bus signals of the Z80-style bus cycle initiator.
// The master modport is the initiator's view; slave is the host/bus model's view.
interface nx1_zbus_master_if;
  logic        I_REQ;
  logic        I_IO;
  logic        I_WE;
  logic [15:0] I_ADDR;
  logic [7:0]  I_WDATA;
  logic        O_ACK;
  logic [7:0]  O_RDATA;
  logic        O_BUSY;
  logic        O_TIMEOUT;
  logic [15:0] O_A;
  logic [7:0]  O_D;
  logic        O_D_OE;
  logic [7:0]  I_D;
  logic        O_MREQ_n;
  logic        O_IORQ_n;
  logic        O_RD_n;
  logic        O_WR_n;
  logic        I_WAIT_n;

  modport master (
    input  I_REQ, I_IO, I_WE, I_ADDR, I_WDATA, I_D, I_WAIT_n,
    output O_ACK, O_RDATA, O_BUSY, O_TIMEOUT, O_A, O_D, O_D_OE,
           O_MREQ_n, O_IORQ_n, O_RD_n, O_WR_n
  );

  modport slave (
    output I_REQ, I_IO, I_WE, I_ADDR, I_WDATA, I_D, I_WAIT_n,
    input  O_ACK, O_RDATA, O_BUSY, O_TIMEOUT, O_A, O_D, O_D_OE,
           O_MREQ_n, O_IORQ_n, O_RD_n, O_WR_n
  );
endinterface

// File: rtl/nx1_zbus_master.sv
// Z80-style T1/T2/TW/T3 bus cycle initiator for the X1 system bus (memory and I/O, read and write).
// Optional macro ZBUS_WAIT_TIMEOUT_EN bounds TW at WAIT_MAX states and raises sticky O_TIMEOUT.
//
// state | meaning
// IDLE  | waiting for I_REQ; request fields latched on acceptance
// T1    | address (and write data) driven, strobes inactive
// T2    | MREQ_n/IORQ_n and RD_n/WR_n asserted
// TWA   | automatic I/O wait states (IO_AUTO_WAIT of them)
// TW    | wait states while I_WAIT_n is low
// T3    | final strobe T-state; read data captured on its last clock
// DONE  | strobes released, one-clock O_ACK
module nx1_zbus_master #(
  parameter int TSTATE_CLKS  = 1,
  parameter int IO_AUTO_WAIT = 1,
  parameter int WAIT_MAX     = 255
) (
  input  logic                I_CLK,
  input  logic                I_RESET_n,
  nx1_zbus_master_if.master   bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T1,
    ST_T2,
    ST_TWA,
    ST_TW,
    ST_T3,
    ST_DONE
  } state_t;

  localparam logic [3:0] DIV_LOAD = 4'(TSTATE_CLKS - 1);
  localparam logic [1:0] TWA_LOAD = 2'(IO_AUTO_WAIT - 1);

  state_t      state;
  logic [3:0]  div_cnt;
  logic [1:0]  twa_cnt;
  logic        cyc_io;
  logic        cyc_we;
  logic        ack_q;
  logic        busy_q;
  logic        d_oe_q;
  logic        mreq_q;
  logic        iorq_q;
  logic        rd_q;
  logic        wr_q;
  logic [7:0]  rdata_q;
  logic [7:0]  d_q;
  logic [15:0] a_q;
  logic        t_last;

  assign t_last = (div_cnt == 4'd0);

`ifdef ZBUS_WAIT_TIMEOUT_EN
  localparam logic [7:0] TW_LOAD = 8'(WAIT_MAX - 1);
  logic [7:0] tw_cnt;
  logic       tmo_q;
  assign bus.O_TIMEOUT = tmo_q;
`else
  logic unused_wait_max;
  assign unused_wait_max = ^WAIT_MAX;
  assign bus.O_TIMEOUT   = 1'b0;
`endif

  always_ff @(posedge I_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      state   <= ST_IDLE;
      div_cnt <= 4'd0;
      twa_cnt <= 2'd0;
      cyc_io  <= 1'b0;
      cyc_we  <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      d_oe_q  <= 1'b0;
      mreq_q  <= 1'b1;
      iorq_q  <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      rdata_q <= 8'd0;
      d_q     <= 8'd0;
      a_q     <= 16'd0;
`ifdef ZBUS_WAIT_TIMEOUT_EN
      tw_cnt  <= 8'd0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      ack_q   <= 1'b0;
      // T-state divider free-runs; acceptance reloads it so T1 starts aligned
      div_cnt <= t_last ? DIV_LOAD : div_cnt - 4'd1;
      case (state)
        ST_IDLE: begin
          if (bus.I_REQ) begin
            cyc_io  <= bus.I_IO;
            cyc_we  <= bus.I_WE;
            a_q     <= bus.I_ADDR;
            if (bus.I_WE) d_q <= bus.I_WDATA;
            d_oe_q  <= bus.I_WE;
            busy_q  <= 1'b1;
            div_cnt <= DIV_LOAD;
`ifdef ZBUS_WAIT_TIMEOUT_EN
            tmo_q   <= 1'b0;
`endif
            state   <= ST_T1;
          end
        end
        ST_T1: begin
          if (t_last) begin
            mreq_q <= cyc_io;
            iorq_q <= ~cyc_io;
            rd_q   <= cyc_we;
            wr_q   <= ~cyc_we;
            state  <= ST_T2;
          end
        end
        ST_T2: begin
          if (t_last) begin
`ifdef ZBUS_WAIT_TIMEOUT_EN
            tw_cnt <= TW_LOAD;
`endif
            if (cyc_io && (IO_AUTO_WAIT != 0)) begin
              twa_cnt <= TWA_LOAD;
              state   <= ST_TWA;
            end else begin
              state <= bus.I_WAIT_n ? ST_T3 : ST_TW;
            end
          end
        end
        ST_TWA: begin
          if (t_last) begin
            if (twa_cnt == 2'd0) state <= bus.I_WAIT_n ? ST_T3 : ST_TW;
            else twa_cnt <= twa_cnt - 2'd1;
          end
        end
        ST_TW: begin
          if (t_last) begin
            if (bus.I_WAIT_n) begin
              state <= ST_T3;
            end
`ifdef ZBUS_WAIT_TIMEOUT_EN
            else if (tw_cnt == 8'd0) begin
              tmo_q <= 1'b1;
              state <= ST_T3;
            end else begin
              tw_cnt <= tw_cnt - 8'd1;
            end
`endif
          end
        end
        ST_T3: begin
          if (t_last) begin
            if (!cyc_we) rdata_q <= bus.I_D;
            mreq_q <= 1'b1;
            iorq_q <= 1'b1;
            rd_q   <= 1'b1;
            wr_q   <= 1'b1;
            d_oe_q <= 1'b0;
            ack_q  <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.O_ACK    = ack_q;
  assign bus.O_RDATA  = rdata_q;
  assign bus.O_BUSY   = busy_q;
  assign bus.O_A      = a_q;
  assign bus.O_D      = d_q;
  assign bus.O_D_OE   = d_oe_q;
  assign bus.O_MREQ_n = mreq_q;
  assign bus.O_IORQ_n = iorq_q;
  assign bus.O_RD_n   = rd_q;
  assign bus.O_WR_n   = wr_q;

endmodule

// File: tb/tb_nx1_zbus_master.sv
// Bench for nx1_zbus_master: scoreboard of expected cycle results, checked when O_ACK appears.
// Timeout scenario is exercised only when ZBUS_WAIT_TIMEOUT_EN is defined.
module tb_nx1_zbus_master;

  logic I_CLK = 1'b0;
  logic I_RESET_n;

  always #5 I_CLK = ~I_CLK;

  nx1_zbus_master_if bus ();
  nx1_zbus_master_if bus4 ();

  nx1_zbus_master #(.TSTATE_CLKS(1), .IO_AUTO_WAIT(1), .WAIT_MAX(4)) dut (
    .I_CLK     (I_CLK),
    .I_RESET_n (I_RESET_n),
    .bus       (bus.master)
  );

  nx1_zbus_master #(.TSTATE_CLKS(4), .IO_AUTO_WAIT(1), .WAIT_MAX(255)) dut4 (
    .I_CLK     (I_CLK),
    .I_RESET_n (I_RESET_n),
    .bus       (bus4.master)
  );

  typedef struct {
    logic        io;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          lat;
    int          sclk;
    logic        tmo;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] last_rdata = 8'h00;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // lat: clocks from the accepting edge to the O_ACK clock; sclk: clocks the strobes are low;
  // rel: cycle number at which I_WAIT_n is released (-1 = leave as is)
  task automatic run_txn(input logic io, input logic we, input logic [15:0] addr,
                         input logic [7:0] wdata, input logic [7:0] idata,
                         input int lat, input int sclk, input int rel, input logic tmo);
    exp_t e;
    int   cyc = 0, mreq_c = 0, iorq_c = 0, rd_c = 0, wr_c = 0, oe_c = 0, busy_c = 0;
    logic bad_a = 1'b0, bad_d = 1'b0, bad_p = 1'b0, got = 1'b0;
    @(negedge I_CLK);
    bus.I_IO    = io;
    bus.I_WE    = we;
    bus.I_ADDR  = addr;
    bus.I_WDATA = wdata;
    bus.I_D     = idata;
    bus.I_REQ   = 1'b1;
    e.io = io; e.we = we; e.addr = addr; e.wdata = wdata;
    e.rdata = we ? last_rdata : idata;
    e.lat = lat; e.sclk = sclk; e.tmo = tmo;
    if (!we) last_rdata = idata;
    sb_q.push_back(e);
    @(posedge I_CLK);
    #1;
    bus.I_REQ   = 1'b0;
    bus.I_ADDR  = ~addr;
    bus.I_WDATA = ~wdata;
    bus.I_IO    = ~io;
    bus.I_WE    = ~we;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge I_CLK);
      cyc++;
      if (!bus.O_MREQ_n) mreq_c++;
      if (!bus.O_IORQ_n) iorq_c++;
      if (!bus.O_RD_n) rd_c++;
      if (!bus.O_WR_n) wr_c++;
      if (bus.O_D_OE) oe_c++;
      if (bus.O_BUSY) busy_c++;
      if ((!bus.O_RD_n && !bus.O_WR_n) || (!bus.O_MREQ_n && !bus.O_IORQ_n)) bad_p = 1'b1;
      if (!bus.O_MREQ_n || !bus.O_IORQ_n) begin
        if (bus.O_A !== addr) bad_a = 1'b1;
        if (we && (bus.O_D_OE !== 1'b1 || bus.O_D !== wdata)) bad_d = 1'b1;
      end
      if (!we && bus.O_D_OE !== 1'b0) bad_d = 1'b1;
      if (bus.O_ACK) begin
        got = 1'b1;
        e = sb_q.pop_front();
        check("latency", cyc, e.lat);
        check("rdata", bus.O_RDATA, e.rdata);
        check("mreq_clks", mreq_c, e.io ? 0 : e.sclk);
        check("iorq_clks", iorq_c, e.io ? e.sclk : 0);
        check("rd_clks", rd_c, e.we ? 0 : e.sclk);
        check("wr_clks", wr_c, e.we ? e.sclk : 0);
        check("d_oe_clks", oe_c, e.we ? e.sclk + 1 : 0);
        check("busy_clks", busy_c, e.lat);
        check("addr_data_proto", {bad_a, bad_d, bad_p}, 0);
        check("timeout_flag", bus.O_TIMEOUT, e.tmo);
      end else if (cyc == rel) begin
        bus.I_WAIT_n = 1'b1;
      end
    end
    if (!got) begin
      check("ack_seen", 0, 1);
      sb_q.delete();
    end
    @(negedge I_CLK);
    check("ack_pulse_idle", {bus.O_ACK, bus.O_BUSY}, 0);
  endtask

  initial begin
    int   n, mc, rc;
    logic got4, ack_in_rst;
    bus.I_REQ = 0; bus.I_IO = 0; bus.I_WE = 0; bus.I_ADDR = 0; bus.I_WDATA = 0;
    bus.I_D = 0; bus.I_WAIT_n = 1;
    bus4.I_REQ = 0; bus4.I_IO = 0; bus4.I_WE = 0; bus4.I_ADDR = 0; bus4.I_WDATA = 0;
    bus4.I_D = 0; bus4.I_WAIT_n = 1;
    I_RESET_n = 1'b1;
    #2 I_RESET_n = 1'b0;
    #1;
    check("rst_strobes", {bus.O_MREQ_n, bus.O_IORQ_n, bus.O_RD_n, bus.O_WR_n}, 4'hF);
    check("rst_flags", {bus.O_ACK, bus.O_BUSY, bus.O_TIMEOUT, bus.O_D_OE}, 0);
    check("rst_addr", bus.O_A, 0);
    check("rst_data", {bus.O_D, bus.O_RDATA}, 0);
    repeat (2) @(negedge I_CLK);
    I_RESET_n = 1'b1;

    run_txn(1'b0, 1'b0, 16'h8000, 8'h00, 8'h5A, 4, 2, -1, 1'b0);
    run_txn(1'b1, 1'b1, 16'h1A02, 8'hC3, 8'h00, 5, 3, -1, 1'b0);
    bus.I_WAIT_n = 1'b0;
    run_txn(1'b0, 1'b1, 16'h4321, 8'h96, 8'h00, 7, 5, 5, 1'b0);
    run_txn(1'b1, 1'b0, 16'h00FE, 8'h00, 8'hA5, 5, 3, -1, 1'b0);

    // abort an I/O read stuck in TW with reset
    bus.I_WAIT_n = 1'b0;
    @(negedge I_CLK);
    bus.I_IO = 1'b1; bus.I_WE = 1'b0; bus.I_ADDR = 16'h2233; bus.I_D = 8'h66; bus.I_REQ = 1'b1;
    @(posedge I_CLK);
    #1 bus.I_REQ = 1'b0;
    repeat (4) @(negedge I_CLK);
    #1;
    check("pre_rst_iorq_rd", {bus.O_IORQ_n, bus.O_RD_n}, 0);
    I_RESET_n = 1'b0;
    #1;
    check("arst_strobes", {bus.O_MREQ_n, bus.O_IORQ_n, bus.O_RD_n, bus.O_WR_n}, 4'hF);
    check("arst_flags", {bus.O_ACK, bus.O_BUSY, bus.O_D_OE}, 0);
    check("arst_rdata", bus.O_RDATA, 0);
    last_rdata = 8'h00;
    ack_in_rst = 1'b0;
    repeat (3) begin
      @(negedge I_CLK);
      if (bus.O_ACK) ack_in_rst = 1'b1;
    end
    I_RESET_n = 1'b1;
    bus.I_WAIT_n = 1'b1;
    repeat (2) begin
      @(negedge I_CLK);
      if (bus.O_ACK) ack_in_rst = 1'b1;
    end
    check("no_ack_after_abort", ack_in_rst, 0);
    run_txn(1'b0, 1'b0, 16'h1234, 8'h00, 8'h3C, 4, 2, -1, 1'b0);

`ifdef ZBUS_WAIT_TIMEOUT_EN
    bus.I_WAIT_n = 1'b0;
    run_txn(1'b0, 1'b0, 16'h0040, 8'h00, 8'hE7, 8, 6, -1, 1'b1);
    bus.I_WAIT_n = 1'b1;
    run_txn(1'b0, 1'b0, 16'h0041, 8'h00, 8'h18, 4, 2, -1, 1'b0);
`endif

    // TSTATE_CLKS=4 memory read: I_D changes right before the last clock of T3
    @(negedge I_CLK);
    bus4.I_IO = 1'b0; bus4.I_WE = 1'b0; bus4.I_ADDR = 16'h8000; bus4.I_D = 8'h11; bus4.I_REQ = 1'b1;
    @(posedge I_CLK);
    #1 bus4.I_REQ = 1'b0;
    n = 0; mc = 0; rc = 0; got4 = 1'b0;
    for (int i = 0; i < 40 && !got4; i++) begin
      @(negedge I_CLK);
      n++;
      if (!bus4.O_MREQ_n) mc++;
      if (!bus4.O_RD_n) rc++;
      if (bus4.O_ACK) got4 = 1'b1;
      else if (n == 12) bus4.I_D = 8'h77;
    end
    check("t4_latency", n, 13);
    check("t4_rdata", bus4.O_RDATA, 8'h77);
    check("t4_mreq_clks", mc, 8);
    check("t4_rd_clks", rc, 8);
    check("t4_addr", bus4.O_A, 16'h8000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
